instruction_queue: RTL and testbench



---
 rtl/rv32i_types.sv | 10 +
 rtl/instruction_queue_if.sv | 24 ++
 rtl/instruction_queue.sv | 58 +++++
 tb/tb_instruction_queue.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word and instruction-queue entry types.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef struct packed {
    rv32i_word pc;
    rv32i_word inst;
    rv32i_word pc_next;
    logic      br_pred;
  } iq_entry_t;
endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch push handshake and dispatch pop bus of the instruction queue.
interface instruction_queue_if;
  import rv32i_types::*;
  logic      iq_valid;
  logic      iq_ready;
  rv32i_word pc;
  rv32i_word inst;
  rv32i_word pc_next;
  logic      br_pred;
  logic      out_valid;
  logic      out_ready;
  rv32i_word out_pc;
  rv32i_word out_inst;
  rv32i_word out_pc_next;
  logic      out_br_pred;
  modport slave (
    input  iq_valid, pc, inst, pc_next, br_pred, out_ready,
    output iq_ready, out_valid, out_pc, out_inst, out_pc_next, out_br_pred
  );
  modport master (
    output iq_valid, pc, inst, pc_next, br_pred, out_ready,
    input  iq_ready, out_valid, out_pc, out_inst, out_pc_next, out_br_pred
  );
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: circular fetch-to-dispatch buffer with flush.
// IQ_BYPASS_EN: an empty queue forwards the incoming entry to the output in the same cycle.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic flush,
  instruction_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   cnt_q, cnt_d;
  iq_entry_t     mem_q [DEPTH];
  iq_entry_t     in_e, out_e;
  logic          empty, full, byp, push, pop;
  assign in_e  = '{pc: bus.pc, inst: bus.inst, pc_next: bus.pc_next, br_pred: bus.br_pred};
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
`ifdef IQ_BYPASS_EN
  assign byp = empty && bus.iq_valid && !flush;
`else
  assign byp = 1'b0;
`endif
  assign bus.iq_ready  = !full && !rst;
  assign bus.out_valid = (!empty || byp) && !rst;
  assign out_e           = byp ? in_e : mem_q[head_q];
  assign bus.out_pc      = out_e.pc;
  assign bus.out_inst    = out_e.inst;
  assign bus.out_pc_next = out_e.pc_next;
  assign bus.out_br_pred = out_e.br_pred;
  // a bypassed entry consumed this cycle never touches storage
  assign push = bus.iq_valid && bus.iq_ready && !(byp && bus.out_ready);
  assign pop  = !empty && bus.out_ready && !rst;
  always_comb begin
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
    cnt_d  = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (push && !flush) mem_q[tail_q] <= in_e;
    end
  end
  always_ff @(posedge clk)
    assert (rst || !bus.iq_valid || bus.iq_ready)
      else $warning("instruction_queue: push while full dropped");
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: table-driven directed checks of the instruction queue.
module tb_instruction_queue;
  import rv32i_types::*;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  instruction_queue_if bus ();
  instruction_queue #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic      fl;
    logic      v;
    rv32i_word pc;
    logic      rdy;
    logic      e_ready;
    logic      e_valid;
    rv32i_word e_pc;
  } vec_t;
  vec_t vq[$];
  int n_cmp = 0;
  int n_fail = 0;
  function automatic rv32i_word inst_of(rv32i_word p);
    return 32'h0000_0013 ^ ((p - 32'h60) << 12);
  endfunction
  function automatic logic br_of(rv32i_word p);
    return p[2];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(logic fl, logic v, rv32i_word pc, logic rdy, logic er, logic ev, rv32i_word epc);
    vq.push_back('{fl, v, pc, rdy, er, ev, epc});
  endtask
  task automatic drive(logic fl, logic v, rv32i_word pc, logic rdy);
    flush        = fl;
    bus.iq_valid = v;
    bus.pc       = pc;
    bus.inst     = inst_of(pc);
    bus.pc_next  = pc + 32'd4;
    bus.br_pred  = br_of(pc);
    bus.out_ready = rdy;
  endtask
  task automatic chk_head(string name, rv32i_word epc);
    chk({name, ".pc"}, bus.out_pc, epc);
    chk({name, ".inst"}, bus.out_inst, inst_of(epc));
    chk({name, ".pc_next"}, bus.out_pc_next, epc + 32'd4);
    chk({name, ".br"}, 32'(bus.out_br_pred), 32'(br_of(epc)));
  endtask
  initial begin
    drive(0, 0, 0, 0);
    // basic push/pop
    add(0, 0, 0,     0, 1, 0,   0);
    add(0, 1, 'h60,  0, 1, BYP, 'h60);
    add(0, 0, 0,     0, 1, 1,   'h60);
    add(0, 0, 0,     1, 1, 1,   'h60);
    add(0, 0, 0,     0, 1, 0,   0);
    // fill to full
    for (int k = 0; k < 8; k++)
      add(0, 1, 32'h60 + 32'(4 * k), 0, 1, (k != 0) || BYP, 'h60);
    add(0, 0, 0, 0, 0, 1, 'h60);
    // pop 3, push 3 across the wrap point
    add(0, 0, 0, 1, 0, 1, 'h60);
    add(0, 0, 0, 1, 1, 1, 'h64);
    add(0, 0, 0, 1, 1, 1, 'h68);
    add(0, 1, 'h80, 0, 1, 1, 'h6C);
    add(0, 1, 'h84, 0, 1, 1, 'h6C);
    add(0, 1, 'h88, 0, 1, 1, 'h6C);
    add(0, 0, 0,    0, 0, 1, 'h6C);
    // overflow attempt is dropped
    add(0, 1, 'hDEAD0000, 0, 0, 1, 'h6C);
    add(0, 0, 0,          1, 0, 1, 'h6C);
    // simultaneous push and pop at count 7
    add(0, 1, 'h8C, 1, 1, 1, 'h70);
    add(0, 1, 'h90, 1, 1, 1, 'h74);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 1, 1, 1, 32'h78 + 32'(4 * k));
    add(0, 0, 0, 0, 1, 0, 0);
    // flush with 5 entries and a concurrent push
    for (int k = 0; k < 5; k++)
      add(0, 1, 32'h100 + 32'(4 * k), 0, 1, (k != 0) || BYP, 'h100);
    add(1, 1, 'h200, 1, 1, 1, 'h100);
    add(0, 0, 0,     0, 1, 0, 0);
    add(0, 1, 'h300, 0, 1, BYP, 'h300);
    add(0, 0, 0,     0, 1, 1, 'h300);
    add(0, 0, 0,     1, 1, 1, 'h300);
    add(0, 0, 0,     0, 1, 0, 0);
    // same-cycle consume on an empty queue
    add(0, 1, 'h400, 1, 1, BYP, 'h400);
    add(0, 0, 0,     0, 1, !BYP, 'h400);
    add(0, 0, 0,     1, 1, !BYP, 'h400);
    add(0, 0, 0,     0, 1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.iq_ready", 32'(bus.iq_ready), 0);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    rst = 1'b0;
    #1;
    chk("post_rst.iq_ready", 32'(bus.iq_ready), 1);
    chk("post_rst.out_valid", 32'(bus.out_valid), 0);
    chk("post_rst.out_pc", bus.out_pc, 0);
    chk("post_rst.out_inst", bus.out_inst, 0);
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].fl, vq[i].v, vq[i].pc, vq[i].rdy);
      #1;
      chk($sformatf("v%0d.iq_ready", i), 32'(bus.iq_ready), 32'(vq[i].e_ready));
      chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vq[i].e_valid));
      if (vq[i].e_valid) chk_head($sformatf("v%0d", i), vq[i].e_pc);
    end
    // reset mid-operation clears storage and drops the in-flight push
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 'h500, 0);
    @(negedge clk);
    drive(0, 1, 'h504, 0);
    rst = 1'b1;
    #1;
    chk("midrst.iq_ready", 32'(bus.iq_ready), 0);
    chk("midrst.out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst.after_valid", 32'(bus.out_valid), 0);
    chk("midrst.after_ready", 32'(bus.iq_ready), 1);
    chk("midrst.slot0_pc", bus.out_pc, 0);
    chk("midrst.slot0_inst", bus.out_inst, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
